// File: rtl/messenger_rx_if.sv
// messenger_rx_if
// Document write port shared by messenger_rx and text_editor. A writer
// holds wr_req with a stable address/data until the arbiter answers
// with wr_gnt. The write completes on any cycle where both are 1.
//
// Signals:
//   wr_req   - write pending (writer -> arbiter)
//   wr_gnt   - grant         (arbiter -> writer)
//   doc_addr - {row[3:0], col[4:0]} document address
//   doc_data - character to store
interface messenger_rx_if;
   logic       wr_req;
   logic       wr_gnt;
   logic [8:0] doc_addr;
   logic [7:0] doc_data;

   // The receiver side that requests writes
   modport master (
      output wr_req,
      output doc_addr,
      output doc_data,
      input  wr_gnt
   );

   // The arbiter / document RAM side
   modport slave (
      input  wr_req,
      input  doc_addr,
      input  doc_data,
      output wr_gnt
   );
endinterface

// File: rtl/messenger_rx.sv
// messenger_rx
// UART receiver that types into the on-screen document. Frames are
// 8N1 by default, or 8E1 when MESSENGER_RX_PARITY_EN is defined.
// Printable characters are written through the shared document write
// port at a cursor that walks a COLS x ROWS block layout. CR and BS
// move the cursor without writing.
//
// Ports:
//   clk        - system clock, rising edge
//   rst        - synchronous active-low reset
//   RsRx       - asynchronous serial input, idle high
//   clear      - one-cycle pulse, cursor back to 0 and pending write dropped
//   bus        - messenger_rx_if.master (wr_req, wr_gnt, doc_addr, doc_data)
//   frame_err  - sticky, stop bit sampled low
//   overrun    - sticky, byte completed while a write was still pending
//   parity_err - sticky, parity mismatch (constant 0 without MESSENGER_RX_PARITY_EN)
module messenger_rx #(
   parameter int CLK_HZ = 100000000,
   parameter int BAUD   = 9600,
   parameter int COLS   = 20,
   parameter int ROWS   = 15
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          RsRx,
   input  logic          clear,
   messenger_rx_if.master bus,
   output logic          frame_err,
   output logic          overrun,
   output logic          parity_err
);

   localparam int DIV   = CLK_HZ / (BAUD * 16);
   localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;

`ifdef MESSENGER_RX_PARITY_EN
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_HIGH} state_t;
`else
   typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;
`endif

   state_t state, next_state;

   logic             rx_meta, rx_sync;
   logic [DIV_W-1:0] div_cnt;
   logic             tick;
   logic [3:0]       tick_cnt;
   logic [2:0]       bit_cnt;
   logic [7:0]       shift_reg;
   logic             sample, restart, accept, set_ferr, set_perr;
   logic             par_bad;
   logic             wr_req_q;
   logic [8:0]       doc_addr_q;
   logic [7:0]       doc_data_q;
   logic [3:0]       row;
   logic [4:0]       col;

   assign bus.wr_req   = wr_req_q;
   assign bus.doc_addr = doc_addr_q;
   assign bus.doc_data = doc_data_q;

   // Two-stage synchroniser for the asynchronous line. Both stages reset
   // to the idle-high level so reset never looks like a start bit.
   always_ff @(posedge clk) begin
      if (!rst) begin
         rx_meta <= 1'b1;
         rx_sync <= 1'b1;
      end else begin
         rx_meta <= RsRx;
         rx_sync <= rx_meta;
      end
   end

   // Free-running 16x oversample divider. A detected start edge pulls
   // the phase back to 0 so the bit centres line up with that edge.
   assign tick = (div_cnt == DIV_W'(DIV - 1));

   always_ff @(posedge clk) begin
      if (!rst || restart || tick) begin
         div_cnt <= '0;
      end else begin
         div_cnt <= div_cnt + 1'b1;
      end
   end

   // START waits half a bit (8 ticks) to reach the middle of the start
   // bit; every later state waits a full bit (16 ticks) from there.
   assign sample = tick && (tick_cnt == ((state == START) ? 4'd7 : 4'd15));

   // State register for the receive FSM.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state decode. accept/set_ferr/set_perr are single-cycle strobes
   // raised on the stop-bit sample and consumed by the blocks below.
   always_comb begin
      next_state = state;
      restart    = 1'b0;
      accept     = 1'b0;
      set_ferr   = 1'b0;
      set_perr   = 1'b0;
      case (state)
         IDLE: begin
            if (!rx_sync) begin
               next_state = START;
               restart    = 1'b1;
            end
         end
         START: begin
            if (sample) begin
               next_state = rx_sync ? IDLE : DATA;
            end
         end
         DATA: begin
            if (sample && (bit_cnt == 3'd7)) begin
`ifdef MESSENGER_RX_PARITY_EN
               next_state = PARITY;
`else
               next_state = STOP;
`endif
            end
         end
`ifdef MESSENGER_RX_PARITY_EN
         PARITY: begin
            if (sample) begin
               next_state = STOP;
            end
         end
`endif
         STOP: begin
            if (sample) begin
               if (!rx_sync) begin
                  set_ferr   = 1'b1;
                  next_state = WAIT_HIGH;
               end else if (par_bad) begin
                  set_perr   = 1'b1;
                  next_state = IDLE;
               end else begin
                  accept     = 1'b1;
                  next_state = IDLE;
               end
            end
         end
         WAIT_HIGH: begin
            if (rx_sync) begin
               next_state = IDLE;
            end
         end
         default: next_state = IDLE;
      endcase
   end

   // Bit timing and deserialisation. tick_cnt wraps 15->0 by itself in
   // the full-bit states; only the half-bit START wait needs a reload.
   always_ff @(posedge clk) begin
      if (!rst) begin
         tick_cnt  <= 4'd0;
         bit_cnt   <= 3'd0;
         shift_reg <= 8'd0;
      end else begin
         if (restart || (state == START && sample)) begin
            tick_cnt <= 4'd0;
         end else if (tick) begin
            tick_cnt <= tick_cnt + 4'd1;
         end
         if (restart) begin
            bit_cnt <= 3'd0;
         end else if (state == DATA && sample) begin
            shift_reg <= {rx_sync, shift_reg[7:1]};
            bit_cnt   <= bit_cnt + 3'd1;
         end
      end
   end

`ifdef MESSENGER_RX_PARITY_EN
   // Even parity: the parity bit must make the total count of ones even,
   // so it has to equal the XOR of the eight data bits.
   always_ff @(posedge clk) begin
      if (!rst) begin
         par_bad    <= 1'b0;
         parity_err <= 1'b0;
      end else begin
         if (state == PARITY && sample) begin
            par_bad <= rx_sync ^ (^shift_reg);
         end
         if (set_perr) begin
            parity_err <= 1'b1;
         end
      end
   end
`else
   assign par_bad    = 1'b0;
   assign parity_err = 1'b0;
`endif

   // Sticky frame error; only reset clears it.
   always_ff @(posedge clk) begin
      if (!rst) begin
         frame_err <= 1'b0;
      end else if (set_ferr) begin
         frame_err <= 1'b1;
      end
   end

   // Cursor and write-port handling. A pending write blocks every new
   // byte (including CR/BS) so the cursor cannot move under a latched
   // address. clear has top priority; a byte landing on the same cycle
   // as clear is dropped.
   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_req_q   <= 1'b0;
         doc_addr_q <= 9'd0;
         doc_data_q <= 8'd0;
         row        <= 4'd0;
         col        <= 5'd0;
         overrun    <= 1'b0;
      end else begin
         if (accept && wr_req_q) begin
            overrun <= 1'b1;
         end
         if (clear) begin
            row      <= 4'd0;
            col      <= 5'd0;
            wr_req_q <= 1'b0;
         end else if (wr_req_q && bus.wr_gnt) begin
            wr_req_q <= 1'b0;
            if (col == 5'(COLS - 1)) begin
               col <= 5'd0;
               row <= (row == 4'(ROWS - 1)) ? 4'd0 : row + 4'd1;
            end else begin
               col <= col + 5'd1;
            end
         end else if (accept && !wr_req_q) begin
            if (shift_reg >= 8'h20 && shift_reg <= 8'h7E) begin
               doc_data_q <= shift_reg;
               doc_addr_q <= {row, col};
               wr_req_q   <= 1'b1;
            end else if (shift_reg == 8'h0D) begin
               col <= 5'd0;
               row <= (row == 4'(ROWS - 1)) ? 4'd0 : row + 4'd1;
            end else if (shift_reg == 8'h08) begin
               if (col != 5'd0) begin
                  col <= col - 5'd1;
               end else if (row != 4'd0) begin
                  row <= row - 4'd1;
                  col <= 5'(COLS - 1);
               end
            end
         end
      end
   end

endmodule
